can_rx_fifo: RTL and testbench

- Receive-side frame buffer directly downstream of the CAN controller.
- Captures each valid received frame (ID, EXT, RTR, DLC, 8 data bytes) on the controller's frame-available pulse and applies a code/mask acceptance filter.
- Queues accepted frames in a DEPTH-entry FIFO so the TinyQV core can drain them without losing back-to-back frames.
- Provides occupancy, overflow and drop statistics, plus a level interrupt.

---
 rtl/can_rx_fifo.sv | 133 +++++++++++++
 tb/tb_can_rx_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_rx_fifo.sv
// can_rx_fifo
// Receive-side frame buffer sitting behind the CAN controller. Each
// rx_valid pulse presents one complete frame; frames passing the code/mask
// acceptance filter are queued in a DEPTH-entry FIFO for the CPU to drain.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_valid              one-cycle frame-available strobe
//   rx_id/ext/rtr/dlc/data received frame fields
//   filt_en               enable acceptance filter (0 = accept all)
//   acc_code/mask/ext     acceptance code, compare mask, required EXT
//   pop                   discard head entry
//   clr                   synchronous flush (highest priority)
//   irq_en, irq_level     interrupt enable and occupancy threshold
//   head_valid, head_*    head entry (combinational from storage)
//   count, full           occupancy
//   ovf, drop_cnt         sticky overflow flag, saturating drop counter
//   irq                   level interrupt
module can_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [28:0]   rx_id,
  input  logic          rx_ext,
  input  logic          rx_rtr,
  input  logic [3:0]    rx_dlc,
  input  logic [63:0]   rx_data,
  input  logic          filt_en,
  input  logic [28:0]   acc_code,
  input  logic [28:0]   acc_mask,
  input  logic          acc_ext,
  input  logic          pop,
  input  logic          clr,
  input  logic          irq_en,
  input  logic [CW-1:0] irq_level,
  output logic          head_valid,
  output logic [28:0]   head_id,
  output logic          head_ext,
  output logic          head_rtr,
  output logic [3:0]    head_dlc,
  output logic [63:0]   head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          ovf,
  output logic [7:0]    drop_cnt,
  output logic          irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Zero every byte beyond the DLC (capped at 8 naturally, since byte
  // indices only reach 7) and all bytes of a remote frame.
  function automatic logic [63:0] sanitise_data(input logic [63:0] data,
                                                input logic [3:0]  dlc,
                                                input logic        rtr);
    logic [63:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      if (!rtr && (4'(i) < dlc)) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  logic [28:0] mem_id   [DEPTH];
  logic        mem_ext  [DEPTH];
  logic        mem_rtr  [DEPTH];
  logic [3:0]  mem_dlc  [DEPTH];
  logic [63:0] mem_data [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          accept, push_req, do_write, do_pop, drop;
  logic [CW-1:0] irq_thr;

  assign accept = ~filt_en |
                  (((rx_id ^ acc_code) & acc_mask) == 29'd0 && rx_ext == acc_ext);

  assign head_valid = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign push_req   = rx_valid & accept & ~clr;
  assign do_pop     = pop & head_valid & ~clr;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_write   = push_req & (~full | do_pop);
  assign drop       = push_req & full & ~do_pop;

  // Storage is data only: no reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_id[wr_ptr]   <= rx_id;
      mem_ext[wr_ptr]  <= rx_ext;
      mem_rtr[wr_ptr]  <= rx_rtr;
      mem_dlc[wr_ptr]  <= rx_dlc;
      mem_data[wr_ptr] <= sanitise_data(rx_data, rx_dlc, rx_rtr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_write) - CW'(do_pop);
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign head_id   = mem_id[rd_ptr];
  assign head_ext  = mem_ext[rd_ptr];
  assign head_rtr  = mem_rtr[rd_ptr];
  assign head_dlc  = mem_dlc[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // A threshold of 0 behaves as 1; thresholds above DEPTH can never be met.
  assign irq_thr = (irq_level == '0) ? CW'(1) : irq_level;
  assign irq     = irq_en & (count >= irq_thr);

endmodule

// File: tb/tb_can_rx_fifo.sv
module tb_can_rx_fifo;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid, rx_ext, rx_rtr;
  logic [28:0]   rx_id;
  logic [3:0]    rx_dlc;
  logic [63:0]   rx_data;
  logic          filt_en, acc_ext;
  logic [28:0]   acc_code, acc_mask;
  logic          pop, clr, irq_en;
  logic [CW-1:0] irq_level;
  logic          head_valid, head_ext, head_rtr, full, ovf, irq;
  logic [28:0]   head_id;
  logic [3:0]    head_dlc;
  logic [63:0]   head_data;
  logic [CW-1:0] count;
  logic [7:0]    drop_cnt;

  can_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_id(rx_id),
    .rx_ext(rx_ext), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc), .rx_data(rx_data),
    .filt_en(filt_en), .acc_code(acc_code), .acc_mask(acc_mask),
    .acc_ext(acc_ext), .pop(pop), .clr(clr), .irq_en(irq_en),
    .irq_level(irq_level), .head_valid(head_valid), .head_id(head_id),
    .head_ext(head_ext), .head_rtr(head_rtr), .head_dlc(head_dlc),
    .head_data(head_data), .count(count), .full(full), .ovf(ovf),
    .drop_cnt(drop_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [28:0] id;
    logic        ext;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;

  frame_t m_q[$];
  int     m_drops;
  bit     m_ovf;
  int     tests = 0;
  int     fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_data(input logic [63:0] d, input logic [3:0] dlc,
                                           input logic rtr);
    int n;
    n = rtr ? 0 : ((dlc > 8) ? 8 : int'(dlc));
    if (n == 8) return d;
    return d & ((64'd1 << (8 * n)) - 64'd1);
  endfunction

  function automatic void model_clear();
    m_q.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
  endfunction

  // Applies the inputs seen at a clock edge to the reference queue.
  function automatic void model_update();
    bit acc, popped;
    frame_t f;
    if (clr) begin
      model_clear();
      return;
    end
    acc = !filt_en ||
          ((((rx_id ^ acc_code) & acc_mask) == 0) && (rx_ext == acc_ext));
    popped = pop && (m_q.size() > 0);
    if (popped) void'(m_q.pop_front());
    if (rx_valid && acc) begin
      if (m_q.size() < DEPTH) begin
        f.id = rx_id; f.ext = rx_ext; f.rtr = rx_rtr; f.dlc = rx_dlc;
        f.data = ref_data(rx_data, rx_dlc, rx_rtr);
        m_q.push_back(f);
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
  endfunction

  function automatic bit model_irq();
    int thr;
    thr = (irq_level == 0) ? 1 : int'(irq_level);
    return irq_en && (m_q.size() >= thr);
  endfunction

  task automatic compare_all();
    check("head_valid", 64'(head_valid), 64'(m_q.size() > 0));
    check("count", 64'(count), 64'(m_q.size()));
    check("full", 64'(full), 64'(m_q.size() == DEPTH));
    check("ovf", 64'(ovf), 64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
    check("irq", 64'(irq), 64'(model_irq()));
    if (m_q.size() > 0) begin
      check("head_id", 64'(head_id), 64'(m_q[0].id));
      check("head_ext", 64'(head_ext), 64'(m_q[0].ext));
      check("head_rtr", 64'(head_rtr), 64'(m_q[0].rtr));
      check("head_dlc", 64'(head_dlc), 64'(m_q[0].dlc));
      check("head_data", head_data, m_q[0].data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    rx_valid = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic set_frame(input logic [28:0] id, input logic ext, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] data);
    rx_id = id; rx_ext = ext; rx_rtr = rtr; rx_dlc = dlc; rx_data = data;
    rx_valid = 1'b1;
  endtask

  task automatic push(input logic [28:0] id, input logic ext, input logic rtr,
                      input logic [3:0] dlc, input logic [63:0] data);
    set_frame(id, ext, rtr, dlc, data);
    step();
  endtask

  task automatic pop1();
    pop = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 0; rx_id = 0; rx_ext = 0; rx_rtr = 0; rx_dlc = 0;
    rx_data = 0; filt_en = 0; acc_code = 0; acc_mask = 0; acc_ext = 0;
    pop = 0; clr = 0; irq_en = 1; irq_level = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_head_valid", 64'(head_valid), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    rst_n = 1'b1;
    irq_en = 0;

    // Three unfiltered frames, drained in order
    push(29'h123, 0, 0, 4'd2, 64'h0123_4567_89AB_CDEF);
    push(29'h7FF, 0, 0, 4'd8, 64'hDEAD_BEEF_CAFE_F00D);
    push(29'h1ABCDEF0, 1, 0, 4'd0, 64'h1111_2222_3333_4444);
    check("three_count", 64'(count), 64'd3);
    check("first_id", 64'(head_id), 64'h123);
    check("first_data", head_data, 64'h0000_0000_0000_CDEF);
    pop1(); pop1();
    check("third_id", 64'(head_id), 64'h1ABCDEF0);
    check("third_ext", 64'(head_ext), 64'd1);
    pop1();
    check("empty_after_3", 64'(head_valid), 64'd0);

    // Acceptance filter
    filt_en = 1; acc_code = 29'h120; acc_mask = 29'h7F0; acc_ext = 0;
    push(29'h12F, 0, 0, 4'd1, 64'hAA);
    check("filt_hit", 64'(count), 64'd1);
    push(29'h130, 0, 0, 4'd1, 64'hBB);
    check("filt_miss", 64'(count), 64'd1);
    check("filt_miss_drop", 64'(drop_cnt), 64'd0);
    push(29'h120, 1, 0, 4'd1, 64'hCC);
    check("filt_ext", 64'(count), 64'd1);
    pop1();
    filt_en = 0;

    // Overflow, then flush
    for (int i = 0; i < 6; i++) push(29'(16'h200 + i), 0, 0, 4'd8, 64'(i));
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_full", 64'(full), 64'd1);
    check("ovf_flag", 64'(ovf), 64'd1);
    check("ovf_drops", 64'(drop_cnt), 64'd2);
    check("ovf_head", 64'(head_id), 64'h200);
    clr = 1; step();
    check("clr_count", 64'(count), 64'd0);
    check("clr_ovf", 64'(ovf), 64'd0);
    check("clr_drop", 64'(drop_cnt), 64'd0);

    // Data sanitising
    push(29'h10, 0, 0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    check("san_dlc3", head_data, 64'h0000_0000_00FF_FFFF);
    pop1();
    push(29'h11, 0, 1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    check("san_rtr", head_data, 64'd0);
    pop1();
    push(29'h12, 0, 0, 4'd12, 64'h8877_6655_4433_2211);
    check("san_dlc12_data", head_data, 64'h8877_6655_4433_2211);
    check("san_dlc12_dlc", 64'(head_dlc), 64'd12);
    pop1();

    // Push+pop on a full FIFO, then on an empty one
    for (int i = 0; i < 4; i++) push(29'(16'h300 + i), 0, 0, 4'd1, 64'(i));
    set_frame(29'h555, 0, 0, 4'd1, 64'h55);
    pop = 1;
    step();
    check("fullpp_drop", 64'(drop_cnt), 64'd0);
    check("fullpp_count", 64'(count), 64'd4);
    pop1(); pop1(); pop1();
    check("fullpp_last", 64'(head_id), 64'h555);
    pop1();
    set_frame(29'h666, 0, 0, 4'd1, 64'h66);
    pop = 1;
    step();
    check("emptypp_count", 64'(count), 64'd1);
    pop1();

    // Interrupt thresholds
    irq_en = 1; irq_level = 2;
    push(29'h1, 0, 0, 4'd0, 0);
    check("irq2_one", 64'(irq), 64'd0);
    push(29'h2, 0, 0, 4'd0, 0);
    check("irq2_two", 64'(irq), 64'd1);
    pop1();
    check("irq2_pop", 64'(irq), 64'd0);
    pop1();
    irq_level = 0;
    push(29'h3, 0, 0, 4'd0, 0);
    check("irq0_one", 64'(irq), 64'd1);
    pop1();
    irq_level = 5;
    for (int i = 0; i < 4; i++) push(29'(i), 0, 0, 4'd0, 0);
    check("irq_never", 64'(irq), 64'd0);
    clr = 1; step();

    // Randomised traffic against the reference queue
    for (int n = 0; n < 3000; n++) begin
      filt_en   = ($urandom_range(0, 3) == 0);
      acc_code  = 29'($urandom_range(0, 15));
      acc_mask  = 29'h3;
      acc_ext   = 1'($urandom_range(0, 1));
      irq_en    = 1'($urandom_range(0, 1));
      irq_level = CW'($urandom_range(0, 7));
      rx_id     = {$urandom_range(0, 1) == 1 ? 25'($urandom) : 25'd0, 4'($urandom)};
      rx_ext    = 1'($urandom_range(0, 1));
      rx_rtr    = ($urandom_range(0, 5) == 0);
      rx_dlc    = 4'($urandom);
      rx_data   = {$urandom, $urandom};
      rx_valid  = ($urandom_range(0, 9) < 6);
      pop       = ($urandom_range(0, 9) < 4);
      clr       = ($urandom_range(0, 199) == 0);
      step();
    end

    // Asynchronous reset in the middle of a cycle
    clr = 1; step();
    filt_en = 0; irq_en = 1; irq_level = 1;
    push(29'h7A, 0, 0, 4'd1, 64'h1);
    push(29'h7B, 0, 0, 4'd1, 64'h2);
    check("pre_arst_count", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_irq", 64'(irq), 64'd0);
    check("arst_head_valid", 64'(head_valid), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
